// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: data_path control line indices,
// opcode values, sequencer state encoding and a small state-class helper.
package control_sequencer_pkg;

  localparam int CTL_INIT_PC  = 0;
  localparam int CTL_ABUS_PC  = 1;
  localparam int CTL_IR_RBUS  = 2;
  localparam int CTL_INC_PC   = 3;
  localparam int CTL_R0_RBUS  = 4;
  localparam int CTL_PC_R0    = 5;
  localparam int CTL_ACC_RBUS = 6;
  localparam int CTL_ADD_OP   = 7;
  localparam int CTL_ACC_ALU  = 8;
  localparam int CTL_WBUS_ACC = 9;
  localparam int CTL_ABUS_R0  = 10;
  localparam int MAX_CONTROL_LINES = 11;

  typedef logic [0:MAX_CONTROL_LINES-1] ctrl_vec_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_STA  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_INC1   = 4'd2,
    S_DECODE = 4'd3,
    S_OPER   = 4'd4,
    S_INC2   = 4'd5,
    S_JUMP   = 4'd6,
    S_MEMRD  = 4'd7,
    S_ALU    = 4'd8,
    S_MEMWR  = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  // States that wait on the memory ready handshake
  function automatic logic is_mem_state(input state_t s);
    logic r;
    case (s)
      S_FETCH, S_OPER, S_MEMRD, S_MEMWR: r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_sequencer_mem_wait_timer.sv
// Memory wait-state counter: clears on state change, counts stalled cycles and
// flags the cycle in which the stall reaches WAIT_LIMIT.
module control_sequencer_mem_wait_timer #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_LIMIT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Stall counter; clear has priority over counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign timeout = en && (cnt_r == LAST_CNT);

endmodule

// File: rtl/control_sequencer.sv
// Fetch / operand / execute sequencer for the single-accumulator data_path.
// Control lines are Moore per state, with the bus-load strobes gated by mem_rdy.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     IR,
  input  logic                           Z,
  input  logic                           mem_rdy,
  output logic [0:MAX_CONTROL_LINES-1]   control,
  output logic                           mem_rd,
  output logic                           mem_wr,
  output logic                           halted,
  output logic                           err
);

  state_t    state_r, next_state_s;
  ctrl_vec_t control_s;
  logic      mem_rd_s, mem_wr_s, set_err_s;
  logic      halted_r, err_r;
  logic      timeout_s, wait_en_s, wait_clr_s;

  assign wait_en_s  = is_mem_state(state_r) && !mem_rdy;
  assign wait_clr_s = (next_state_s != state_r);

  control_sequencer_mem_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (CNT_W)
  ) u_wait (
    .clk     (clk),
    .rst     (rst),
    .clr     (wait_clr_s),
    .en      (wait_en_s),
    .timeout (timeout_s)
  );

  // State register plus sticky halt/error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_RESET;
      halted_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      halted_r <= halted_r | (next_state_s == S_HALT);
      err_r    <= err_r | set_err_s;
    end
  end

  // Next-state and control decode
  always_comb begin
    next_state_s = state_r;
    control_s    = {MAX_CONTROL_LINES{1'b0}};
    mem_rd_s     = 1'b0;
    mem_wr_s     = 1'b0;
    set_err_s    = 1'b0;
    case (state_r)
      S_RESET: begin
        control_s[CTL_INIT_PC] = 1'b1;
        next_state_s = S_FETCH;
      end
      S_FETCH: begin
        control_s[CTL_ABUS_PC] = 1'b1;
        control_s[CTL_IR_RBUS] = mem_rdy;
        mem_rd_s = 1'b1;
        if (mem_rdy) next_state_s = S_INC1;
        else         next_state_s = state_r;
      end
      S_INC1: begin
        control_s[CTL_INC_PC] = 1'b1;
        next_state_s = S_DECODE;
      end
      S_DECODE: begin
        case (IR)
          OP_NOP:                            next_state_s = S_FETCH;
          OP_HALT:                           next_state_s = S_HALT;
          OP_LDA, OP_STA, OP_ADD, OP_JMP, OP_JZ: next_state_s = S_OPER;
          default: begin
            next_state_s = S_HALT;
            set_err_s    = 1'b1;
          end
        endcase
      end
      S_OPER: begin
        control_s[CTL_ABUS_PC] = 1'b1;
        control_s[CTL_R0_RBUS] = mem_rdy;
        mem_rd_s = 1'b1;
        if (mem_rdy) next_state_s = S_INC2;
        else         next_state_s = state_r;
      end
      S_INC2: begin
        control_s[CTL_INC_PC] = 1'b1;
        case (IR)
          OP_JMP:         next_state_s = S_JUMP;
          OP_JZ:          next_state_s = Z ? S_JUMP : S_FETCH;
          OP_LDA, OP_ADD: next_state_s = S_MEMRD;
          OP_STA:         next_state_s = S_MEMWR;
          default: begin
            next_state_s = S_HALT;
            set_err_s    = 1'b1;
          end
        endcase
      end
      S_JUMP: begin
        control_s[CTL_PC_R0] = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMRD: begin
        control_s[CTL_ABUS_R0] = 1'b1;
        mem_rd_s = 1'b1;
        // ADD stages the operand in R0; LDA loads the accumulator directly
        if (IR == OP_ADD) begin
          control_s[CTL_R0_RBUS] = mem_rdy;
          next_state_s = mem_rdy ? S_ALU : state_r;
        end else begin
          control_s[CTL_ACC_RBUS] = mem_rdy;
          next_state_s = mem_rdy ? S_FETCH : state_r;
        end
      end
      S_ALU: begin
        control_s[CTL_ADD_OP]  = 1'b1;
        control_s[CTL_ACC_ALU] = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWR: begin
        control_s[CTL_ABUS_R0]  = 1'b1;
        control_s[CTL_WBUS_ACC] = 1'b1;
        mem_wr_s = 1'b1;
        if (mem_rdy) next_state_s = S_FETCH;
        else         next_state_s = state_r;
      end
      S_HALT: begin
        next_state_s = S_HALT;
      end
      default: begin
        next_state_s = S_HALT;
        set_err_s    = 1'b1;
      end
    endcase
    if (timeout_s) begin
      next_state_s = S_HALT;
      set_err_s    = 1'b1;
    end else begin
      next_state_s = next_state_s;
    end
  end

  // Reset forces every output low immediately, even mid-access
  assign control = rst ? {MAX_CONTROL_LINES{1'b0}} : control_s;
  assign mem_rd  = !rst && mem_rd_s;
  assign mem_wr  = !rst && mem_wr_s;
  assign halted  = halted_r;
  assign err     = err_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle expected outputs go through a
// scoreboard queue and are checked on the falling clock edge.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  typedef struct packed {
    ctrl_vec_t ctrl;
    logic      rd;
    logic      wr;
    logic      hlt;
    logic      er;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] IR = 4'h0;
  logic       Z = 1'b0;
  logic       mem_rdy = 1'b0;
  ctrl_vec_t  control;
  logic       mem_rd, mem_wr, halted, err;

  int   compared = 0;
  int   mismatched = 0;
  exp_t sb[$];

  control_sequencer #(.WAIT_LIMIT(15), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .IR      (IR),
    .Z       (Z),
    .mem_rdy (mem_rdy),
    .control (control),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .halted  (halted),
    .err     (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic ctrl_vec_t m(input int a = -1, input int b = -1, input int c = -1);
    ctrl_vec_t r;
    r = {MAX_CONTROL_LINES{1'b0}};
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    return r;
  endfunction

  function automatic exp_t e(input ctrl_vec_t c, input logic rd, input logic wr,
                             input logic h, input logic er);
    exp_t r;
    r.ctrl = c; r.rd = rd; r.wr = wr; r.hlt = h; r.er = er;
    return r;
  endfunction

  task automatic chk(input string tag);
    exp_t x, o;
    x = sb.pop_front();
    o = {control, mem_rd, mem_wr, halted, err};
    compared++;
    assert (o === x) else begin
      mismatched++;
      $error("FAIL %s: observed ctrl=%b rd=%b wr=%b halted=%b err=%b, expected ctrl=%b rd=%b wr=%b halted=%b err=%b",
             tag, o.ctrl, o.rd, o.wr, o.hlt, o.er, x.ctrl, x.rd, x.wr, x.hlt, x.er);
    end
  endtask

  // One clock: queue the expectation, check at negedge, move past next rising edge
  task automatic cyc(input exp_t x, input string tag);
    sb.push_back(x);
    @(negedge clk);
    chk(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_dec(input string tag);
    cyc(e(m(CTL_ABUS_PC, CTL_IR_RBUS), 1'b1, 1'b0, 1'b0, 1'b0), {tag, "_fetch"});
    cyc(e(m(CTL_INC_PC), 1'b0, 1'b0, 1'b0, 1'b0), {tag, "_inc1"});
    cyc(e(m(), 1'b0, 1'b0, 1'b0, 1'b0), {tag, "_decode"});
  endtask

  task automatic oper_inc2(input string tag);
    cyc(e(m(CTL_ABUS_PC, CTL_R0_RBUS), 1'b1, 1'b0, 1'b0, 1'b0), {tag, "_oper"});
    cyc(e(m(CTL_INC_PC), 1'b0, 1'b0, 1'b0, 1'b0), {tag, "_inc2"});
  endtask

  initial begin
    // Reset held: everything low
    repeat (2) @(posedge clk);
    #1;
    cyc(e(m(), 1'b0, 1'b0, 1'b0, 1'b0), "reset_hold");
    mem_rdy = 1'b1;
    rst = 1'b0;
    cyc(e(m(CTL_INIT_PC), 1'b0, 1'b0, 1'b0, 1'b0), "init_pc");

    // NOP loops every 3 cycles
    IR = OP_NOP;
    fetch_dec("nop0");
    fetch_dec("nop1");

    // JMP: PC_R0 in the sixth cycle
    IR = OP_JMP;
    fetch_dec("jmp");
    oper_inc2("jmp");
    cyc(e(m(CTL_PC_R0), 1'b0, 1'b0, 1'b0, 1'b0), "jmp_pc_r0");

    // JZ not taken, then taken
    IR = OP_JZ; Z = 1'b0;
    fetch_dec("jz0");
    oper_inc2("jz0");
    Z = 1'b1;
    fetch_dec("jz1");
    oper_inc2("jz1");
    cyc(e(m(CTL_PC_R0), 1'b0, 1'b0, 1'b0, 1'b0), "jz1_pc_r0");
    Z = 1'b0;

    // LDA with zero-wait memory
    IR = OP_LDA;
    fetch_dec("lda");
    oper_inc2("lda");
    cyc(e(m(CTL_ABUS_R0, CTL_ACC_RBUS), 1'b1, 1'b0, 1'b0, 1'b0), "lda_memrd");

    // ADD with three wait cycles on the data read
    IR = OP_ADD;
    fetch_dec("add");
    oper_inc2("add");
    mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc(e(m(CTL_ABUS_R0), 1'b1, 1'b0, 1'b0, 1'b0), "add_memrd_wait");
    mem_rdy = 1'b1;
    cyc(e(m(CTL_ABUS_R0, CTL_R0_RBUS), 1'b1, 1'b0, 1'b0, 1'b0), "add_memrd_rdy");
    cyc(e(m(CTL_ADD_OP, CTL_ACC_ALU), 1'b0, 1'b0, 1'b0, 1'b0), "add_alu");

    // STA: ready arrives in the same cycle the limit is reached, so no error
    IR = OP_STA;
    fetch_dec("sta_late");
    oper_inc2("sta_late");
    mem_rdy = 1'b0;
    for (int i = 0; i < 14; i++)
      cyc(e(m(CTL_ABUS_R0, CTL_WBUS_ACC), 1'b0, 1'b1, 1'b0, 1'b0), "sta_late_wait");
    mem_rdy = 1'b1;
    cyc(e(m(CTL_ABUS_R0, CTL_WBUS_ACC), 1'b0, 1'b1, 1'b0, 1'b0), "sta_late_rdy");

    // STA never acknowledged: 15 write cycles, then error halt
    fetch_dec("sta_to");
    oper_inc2("sta_to");
    mem_rdy = 1'b0;
    for (int i = 0; i < 15; i++)
      cyc(e(m(CTL_ABUS_R0, CTL_WBUS_ACC), 1'b0, 1'b1, 1'b0, 1'b0), "sta_to_wait");
    mem_rdy = 1'b1;
    cyc(e(m(), 1'b0, 1'b0, 1'b1, 1'b1), "sta_to_halt0");
    cyc(e(m(), 1'b0, 1'b0, 1'b1, 1'b1), "sta_to_halt1");

    // Reset clears the sticky flags; HALT opcode stops without error
    rst = 1'b1;
    cyc(e(m(), 1'b0, 1'b0, 1'b0, 1'b0), "reset2_hold");
    rst = 1'b0;
    cyc(e(m(CTL_INIT_PC), 1'b0, 1'b0, 1'b0, 1'b0), "init_pc2");
    IR = OP_HALT;
    fetch_dec("halt");
    cyc(e(m(), 1'b0, 1'b0, 1'b1, 1'b0), "halt_op0");
    cyc(e(m(), 1'b0, 1'b0, 1'b1, 1'b0), "halt_op1");

    // Reset asserted mid-write drops mem_wr without waiting for a clock
    rst = 1'b1;
    cyc(e(m(), 1'b0, 1'b0, 1'b0, 1'b0), "reset3_hold");
    rst = 1'b0;
    cyc(e(m(CTL_INIT_PC), 1'b0, 1'b0, 1'b0, 1'b0), "init_pc3");
    IR = OP_STA;
    fetch_dec("sta_rst");
    oper_inc2("sta_rst");
    mem_rdy = 1'b0;
    cyc(e(m(CTL_ABUS_R0, CTL_WBUS_ACC), 1'b0, 1'b1, 1'b0, 1'b0), "sta_rst_wr");
    #2;
    rst = 1'b1;
    #1;
    sb.push_back(e(m(), 1'b0, 1'b0, 1'b0, 1'b0));
    chk("async_rst_drop");
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_rdy = 1'b1;
    cyc(e(m(CTL_INIT_PC), 1'b0, 1'b0, 1'b0, 1'b0), "init_pc4");

    // Illegal opcode halts with error after decode
    IR = 4'h9;
    fetch_dec("illegal");
    cyc(e(m(), 1'b0, 1'b0, 1'b1, 1'b1), "illegal_halt0");
    cyc(e(m(), 1'b0, 1'b0, 1'b1, 1'b1), "illegal_halt1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
